// File: rtl/sha256_stream_ctrl.sv
// sha256_stream_ctrl
//   Streams 32-bit message words into 512-bit blocks for a sha256_core,
//   starts the core once per block, chains the blocks of a message and
//   presents the final digest on a valid/ready output.
//   Optional macro SHA256_CTRL_WDT_EN: enables a WAIT-state watchdog of
//   TIMEOUT_CYCLES cycles that abandons the message on expiry.
//
// Ports
//   iClk, iReset_n        clock, asynchronous active-low reset
//   iWordValid/iWord/iWordLast, oWordReady   word stream input
//   oCoreStart, oCoreBlock, oCoreLastBlock   block request to the core
//   iCoreDone, iCoreDigest                   core completion and digest
//   oDigestValid, iDigestReady, oDigest      final digest output
//   oBusy                 START/WAIT or a partially filled block
//   oError                one-cycle protocol/watchdog error pulse
module sha256_stream_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         iClk,
    input  logic         iReset_n,
    input  logic         iWordValid,
    input  logic [31:0]  iWord,
    input  logic         iWordLast,
    output logic         oWordReady,
    output logic         oCoreStart,
    output logic [511:0] oCoreBlock,
    output logic         oCoreLastBlock,
    input  logic         iCoreDone,
    input  logic [255:0] iCoreDigest,
    output logic         oDigestValid,
    input  logic         iDigestReady,
    output logic [255:0] oDigest,
    output logic         oBusy,
    output logic         oError
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_OUT
    } state_t;

    state_t     state;
    logic [3:0] wcnt;

`ifdef SHA256_CTRL_WDT_EN
    localparam int unsigned WDT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDT_W-1:0] wdt_cnt;
`endif

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state          <= S_IDLE;
            wcnt           <= '0;
            oWordReady     <= 1'b0;
            oCoreStart     <= 1'b0;
            oCoreBlock     <= '0;
            oCoreLastBlock <= 1'b0;
            oDigestValid   <= 1'b0;
            oDigest        <= '0;
            oBusy          <= 1'b0;
            oError         <= 1'b0;
`ifdef SHA256_CTRL_WDT_EN
            wdt_cnt        <= '0;
`endif
        end else begin
            oCoreStart <= 1'b0;
            oError     <= 1'b0;

            case (state)
                S_IDLE: begin
                    state      <= S_LOAD;
                    oWordReady <= 1'b1;
                end

                S_LOAD: begin
                    if (iWordValid && oWordReady) begin
                        // Slot wcnt lives at bit (15-wcnt)*32; ~wcnt == 15-wcnt.
                        oCoreBlock[{~wcnt, 5'd0} +: 32] <= iWord;
                        if (wcnt == 4'd15) begin
                            oCoreLastBlock <= iWordLast;
                            wcnt           <= '0;
                            oWordReady     <= 1'b0;
                            oCoreStart     <= 1'b1;
                            oBusy          <= 1'b1;
                            state          <= S_START;
                        end else if (iWordLast) begin
                            // Short block: drop it, keep chaining state.
                            oError <= 1'b1;
                            wcnt   <= '0;
                            oBusy  <= 1'b0;
                        end else begin
                            wcnt  <= wcnt + 4'd1;
                            oBusy <= 1'b1;
                        end
                    end
                end

                S_START: begin
                    state <= S_WAIT;
`ifdef SHA256_CTRL_WDT_EN
                    wdt_cnt <= '0;
`endif
                end

                S_WAIT: begin
                    if (iCoreDone) begin
                        oBusy <= 1'b0;
                        if (oCoreLastBlock) begin
                            oDigest      <= iCoreDigest;
                            oDigestValid <= 1'b1;
                            state        <= S_OUT;
                        end else begin
                            oWordReady <= 1'b1;
                            state      <= S_LOAD;
                        end
                    end
`ifdef SHA256_CTRL_WDT_EN
                    else if (wdt_cnt == WDT_W'(TIMEOUT_CYCLES - 1)) begin
                        oError         <= 1'b1;
                        oCoreLastBlock <= 1'b0;
                        wcnt           <= '0;
                        oWordReady     <= 1'b1;
                        oBusy          <= 1'b0;
                        state          <= S_LOAD;
                    end else begin
                        wdt_cnt <= wdt_cnt + WDT_W'(1);
                    end
`endif
                end

                S_OUT: begin
                    if (iDigestReady) begin
                        oDigestValid   <= 1'b0;
                        oCoreLastBlock <= 1'b0;
                        oWordReady     <= 1'b1;
                        state          <= S_LOAD;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_stream_ctrl.sv
// tb_sha256_stream_ctrl
//   Self-checking bench for sha256_stream_ctrl. A behavioural core stub
//   answers each start with a done pulse; it returns the expected final
//   digest on the last block and an unrelated value on chained blocks.
//   Optional macro SHA256_CTRL_WDT_EN: also exercises the watchdog.
module tb_sha256_stream_ctrl;

    localparam int STUB_LAT = 6;

    logic         iClk = 1'b0;
    logic         iReset_n = 1'b1;
    logic         iWordValid = 1'b0;
    logic [31:0]  iWord = '0;
    logic         iWordLast = 1'b0;
    logic         iDigestReady = 1'b0;
    logic         iCoreDone;
    logic [255:0] iCoreDigest;
    logic         oWordReady, oCoreStart, oCoreLastBlock;
    logic [511:0] oCoreBlock;
    logic         oDigestValid, oBusy, oError;
    logic [255:0] oDigest;

    logic         stub_en = 1'b1;
    logic         stub_done = 1'b0;
    logic [255:0] stub_dig = '0;
    logic         man_done = 1'b0;
    logic [255:0] man_dig = '0;
    logic [255:0] cur_digest = '0;

    assign iCoreDone   = stub_done | man_done;
    assign iCoreDigest = stub_done ? stub_dig : man_dig;

    sha256_stream_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .iClk          (iClk),
        .iReset_n      (iReset_n),
        .iWordValid    (iWordValid),
        .iWord         (iWord),
        .iWordLast     (iWordLast),
        .oWordReady    (oWordReady),
        .oCoreStart    (oCoreStart),
        .oCoreBlock    (oCoreBlock),
        .oCoreLastBlock(oCoreLastBlock),
        .iCoreDone     (iCoreDone),
        .iCoreDigest   (iCoreDigest),
        .oDigestValid  (oDigestValid),
        .iDigestReady  (iDigestReady),
        .oDigest       (oDigest),
        .oBusy         (oBusy),
        .oError        (oError)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int            nwords;
        logic [31:0]   last_mask;
        logic [1023:0] words;      // word k at [1023-32*k -: 32]
        int            blk_off;    // word index of first block sent to core
        int            nblk;
        logic [255:0]  digest;
        int            exp_errors;
    } vec_t;

    vec_t         vecs [3];
    logic [1023:0] wbuf;
    logic [31:0]  m2 [14];

    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIG =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    function automatic logic [31:0] abc_word(input int k);
        if (k == 0)  return 32'h61626380;
        if (k == 15) return 32'h00000018;
        return 32'h0;
    endfunction

    // Error-pulse monitor: every pulse must be exactly one cycle wide.
    int   err_pulses = 0;
    logic prev_err = 1'b0;
    initial forever begin
        @(posedge iClk); #1;
        if (oError) begin
            err_pulses++;
            checks++;
            if (prev_err) begin
                failures++;
                $display("FAIL error_pulse_width: got >1 cycle expected 1 cycle");
            end
        end
        prev_err = oError;
    end

    // Core stub.
    logic [511:0] cap_blk  [16];
    logic         cap_last [16];
    int           n_starts = 0;
    initial forever begin
        @(posedge iClk); #1;
        if (stub_en && oCoreStart) begin
            automatic int idx = n_starts % 16;
            cap_blk[idx]  = oCoreBlock;
            cap_last[idx] = oCoreLastBlock;
            n_starts++;
            @(posedge iClk); #1;
            chk("start_pulse_width", oCoreStart, 0);
            repeat (STUB_LAT - 1) begin @(posedge iClk); #1; end
            if (stub_en) begin
                chk("block_stable", oCoreBlock, cap_blk[idx]);
                stub_dig  = oCoreLastBlock ? cur_digest : ~cur_digest;
                stub_done = 1'b1;
                @(posedge iClk); #1;
                stub_done = 1'b0;
            end
        end
    end

    task automatic send_word(input logic [31:0] w, input logic last);
        int n = 0;
        while (!oWordReady && n < 200) begin @(posedge iClk); #1; n++; end
        if (!oWordReady) begin
            chk("word_ready_timeout", oWordReady, 1);
            return;
        end
        iWordValid = 1'b1;
        iWord      = w;
        iWordLast  = last;
        @(posedge iClk); #1;
        iWordValid = 1'b0;
        iWordLast  = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int s0, e0, n;
        logic [511:0] eb;
        v  = vecs[idx];
        s0 = n_starts;
        e0 = err_pulses;
        cur_digest = v.digest;
        for (int k = 0; k < v.nwords; k++)
            send_word(v.words[1023-32*k -: 32], v.last_mask[k]);
        n = 0;
        while (!oDigestValid && n < 500) begin @(posedge iClk); #1; n++; end
        chk($sformatf("v%0d_digest_valid", idx), oDigestValid, 1);
        chk($sformatf("v%0d_digest", idx), oDigest, v.digest);
        iDigestReady = 1'b1;
        @(posedge iClk); #1;
        iDigestReady = 1'b0;
        chk($sformatf("v%0d_valid_clear", idx), oDigestValid, 0);
        chk($sformatf("v%0d_ready_after", idx), oWordReady, 1);
        chk($sformatf("v%0d_starts", idx), n_starts - s0, v.nblk);
        chk($sformatf("v%0d_errors", idx), err_pulses - e0, v.exp_errors);
        for (int b = 0; b < v.nblk; b++) begin
            eb = v.words[1023-32*(v.blk_off+16*b) -: 512];
            chk($sformatf("v%0d_blk%0d", idx, b), cap_blk[(s0+b)%16], eb);
            chk($sformatf("v%0d_last%0d", idx, b), cap_last[(s0+b)%16], (b == v.nblk-1));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] x;
        logic ok;

        // Vector table
        m2 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
               32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
               32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
               32'h6d6e6f70, 32'h6e6f7071};

        wbuf = '0;
        for (int k = 0; k < 16; k++) wbuf[1023-32*k -: 32] = abc_word(k);
        vecs[0] = '{nwords: 16, last_mask: 32'h0000_8000, words: wbuf,
                    blk_off: 0, nblk: 1, digest: ABC_DIG, exp_errors: 0};

        wbuf = '0;
        for (int k = 0; k < 14; k++) wbuf[1023-32*k -: 32] = m2[k];
        wbuf[1023-32*14 -: 32] = 32'h80000000;
        wbuf[31:0]             = 32'h000001c0;
        vecs[1] = '{nwords: 32, last_mask: 32'h8000_0000, words: wbuf,
                    blk_off: 0, nblk: 2, digest: TWO_DIG, exp_errors: 0};

        wbuf = '0;
        for (int k = 0; k < 6; k++)  wbuf[1023-32*k -: 32] = 32'h11111111 * (k + 1);
        for (int k = 0; k < 16; k++) wbuf[1023-32*(k+6) -: 32] = abc_word(k);
        vecs[2] = '{nwords: 22, last_mask: 32'h0020_0020, words: wbuf,
                    blk_off: 6, nblk: 1, digest: ABC_DIG, exp_errors: 1};

        // Reset state
        #2 iReset_n = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        chk("rst_ctrl", {oWordReady, oCoreStart, oCoreLastBlock, oDigestValid, oBusy, oError}, 0);
        chk("rst_block", oCoreBlock, 0);
        chk("rst_digest", oDigest, 0);
        iReset_n = 1'b1;
        @(posedge iClk); #1;
        chk("ready_after_reset", oWordReady, 1);
        chk("busy_idle", oBusy, 0);

        // Table-driven messages
        for (int i = 0; i < 3; i++) run_vec(i);

        // Start/done timing, digest back-pressure, stray done pulses
        stub_en = 1'b0;
        x = 256'h0123456789abcdef_fedcba9876543210_a5a5a5a5a5a5a5a5_5a5a5a5a5a5a5a5a;
        for (int k = 0; k < 16; k++) send_word(abc_word(k), k == 15);
        chk("start_n1", oCoreStart, 1);
        chk("ready_low_start", oWordReady, 0);
        chk("busy_start", oBusy, 1);
        @(posedge iClk); #1;
        chk("start_cleared", oCoreStart, 0);
        chk("last_flag_wait", oCoreLastBlock, 1);
        chk("busy_wait", oBusy, 1);
        chk("block_abc", oCoreBlock, vecs[0].words[1023:512]);
        repeat (3) begin @(posedge iClk); #1; end
        man_dig  = x;
        man_done = 1'b1;
        @(posedge iClk); #1;
        man_done = 1'b0;
        chk("digest_valid_m1", oDigestValid, 1);
        chk("digest_m1", oDigest, x);
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin man_dig = ~x; man_done = 1'b1; end
            @(posedge iClk); #1;
            man_done = 1'b0;
            if (!(oDigestValid === 1'b1 && oDigest === x && oWordReady === 1'b0)) ok = 1'b0;
        end
        chk("hold_stable_50", ok, 1);
        iDigestReady = 1'b1;
        @(posedge iClk); #1;
        iDigestReady = 1'b0;
        chk("ready_after_handshake", oWordReady, 1);
        chk("valid_after_handshake", oDigestValid, 0);
        chk("digest_held", oDigest, x);
        chk("last_cleared", oCoreLastBlock, 0);
        man_dig  = ~x;
        man_done = 1'b1;
        @(posedge iClk); #1;
        man_done = 1'b0;
        chk("stray_done_valid", oDigestValid, 0);
        chk("stray_done_digest", oDigest, x);
        chk("stray_done_ready", oWordReady, 1);

        // Asynchronous reset while waiting on the core
        for (int k = 0; k < 16; k++) send_word(abc_word(k), k == 15);
        repeat (3) begin @(posedge iClk); #1; end
        iReset_n = 1'b0;
        #1;
        chk("wait_rst_ctrl", {oWordReady, oCoreStart, oCoreLastBlock, oDigestValid, oBusy, oError}, 0);
        chk("wait_rst_block", oCoreBlock, 0);
        chk("wait_rst_digest", oDigest, 0);
        @(posedge iClk); #1;
        iReset_n = 1'b1;
        @(posedge iClk); #1;
        chk("ready_after_wait_rst", oWordReady, 1);
        stub_en = 1'b1;
        run_vec(0);

`ifdef SHA256_CTRL_WDT_EN
        // Watchdog with a core that never finishes
        begin
            int e0;
            stub_en = 1'b0;
            e0 = err_pulses;
            for (int k = 0; k < 16; k++) send_word(abc_word(k), k == 15);
            @(posedge iClk); #1;
            ok = 1'b1;
            for (int i = 1; i < 16; i++) begin
                @(posedge iClk); #1;
                if (oError !== 1'b0) ok = 1'b0;
            end
            chk("wdt_no_early_error", ok, 1);
            @(posedge iClk); #1;
            chk("wdt_error", oError, 1);
            chk("wdt_ready", oWordReady, 1);
            chk("wdt_last_clear", oCoreLastBlock, 0);
            @(posedge iClk); #1;
            chk("wdt_error_count", err_pulses - e0, 1);
            stub_en = 1'b1;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha256_stream_ctrl.md
# sha256_stream_ctrl

Sequencer that feeds the `sha256_core` hashing datapath from a 32-bit word stream. It assembles 16 words into a 512-bit block, pulses the core's start, and waits for done. It chains blocks of one message until the word flagged last, then presents the 256-bit digest on a valid/ready output. It replaces register-mapped, software-driven block loading with autonomous streaming; the host supplies already-padded messages.

## Interface
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in cycles for the WAIT state. Used only when `SHA256_CTRL_WDT_EN` is defined.
- `iClk`  in  1  single clock domain for all logic.
- `iReset_n`  in  1  reset, asynchronous, active-low.
- `iWordValid`  in  1  input word valid.
- `iWord`  in  32  message word, big-endian word order.
- `iWordLast`  in  1  marks the final word of the message; legal only on word index 15 of a block.
- `oWordReady`  out  1  controller accepts a word this cycle.
- `oCoreStart`  out  1  one-cycle start pulse to the core.
- `oCoreBlock`  out  512  block to the core; word 0 is in [511:480] and word 15 is in [31:0].
- `oCoreLastBlock`  out  1  last-block flag to the core.
- `iCoreDone`  in  1  core completion pulse.
- `iCoreDigest`  in  256  core digest; valid in the cycle `iCoreDone` is high.
- `oDigestValid`  out  1  `oDigest` holds the final digest.
- `iDigestReady`  in  1  consumer accepts the digest.
- `oDigest`  out  256  registered final digest; H0 is in [255:224].
- `oBusy`  out  1  high in START or WAIT, or when the word count is nonzero.
- `oError`  out  1  one-cycle error pulse.

## Operation
- States: IDLE, LOAD, START, WAIT, OUT. Reset enters IDLE.
- IDLE: unconditionally goes to LOAD on the next clock.
- LOAD: `oWordReady`=1. Each `iWordValid & oWordReady` writes `iWord` into slot `wcnt` and increments the 4-bit `wcnt`.
  - On the accepted word with `wcnt`=15: latch `oCoreLastBlock`=`iWordLast`, clear `wcnt` to 0, go to START.
  - On an accepted word with `wcnt`<15 and `iWordLast`=1: this is a protocol error. Pulse `oError`, clear `wcnt`, discard the partial block, stay in LOAD. Core chaining state is not touched.
- START: `oCoreStart`=1 for exactly one cycle, then go to WAIT.
- WAIT: hold `oCoreBlock` and `oCoreLastBlock` stable until done.
  - On `iCoreDone` with `oCoreLastBlock`=1: latch `iCoreDigest` into `oDigest` and go to OUT.
  - On `iCoreDone` with `oCoreLastBlock`=0: go to LOAD to collect the next block of the same message.
- OUT: `oDigestValid`=1. When `iDigestReady`=1: clear `oDigestValid`, clear `oCoreLastBlock`, go to LOAD.
- `oWordReady`=0 in IDLE, START, WAIT and OUT. Input is stalled; no word is dropped.
- `iCoreDone` outside WAIT is ignored.
- `oDigest` holds its value after the handshake until the next final-block done overwrites it.

## Timing
- All outputs are registered; reset value 0 for every output, `oCoreBlock` and `oDigest` included.
- `oWordReady` rises on the first clock edge after `iReset_n` deasserts (IDLE→LOAD).
- 16th word accepted at edge N → `oCoreStart` high in cycle N+1 → WAIT from N+2.
- `iCoreDone` sampled high at edge M:
  - Last block: `oDigest` and `oDigestValid` are valid from cycle M+1.
  - Not last: `oWordReady`=1 from cycle M+1.
- Digest handshake completes on the edge where `oDigestValid & iDigestReady`. `oWordReady`=1 in the following cycle.
- Back-to-back words are accepted at one per cycle in LOAD. Per-block overhead beyond core latency is 2 cycles (START plus the done→LOAD edge).
- Asynchronous reset mid-operation: state returns to IDLE, `wcnt` clears, all outputs clear. `oCoreStart` is never glitched high. A core that is computing must be reset by the same `iReset_n`.

## Configuration
- `SHA256_CTRL_WDT_EN` defined: a cycle counter runs in WAIT and clears on entry to WAIT.
  - If the counter reaches `TIMEOUT_CYCLES` without `iCoreDone`: pulse `oError`, clear `oCoreLastBlock` and `wcnt`, go to LOAD. The message is abandoned.
  - `iCoreDone` in that same cycle takes priority over the timeout.
- `SHA256_CTRL_WDT_EN` undefined: no counter is built. WAIT waits indefinitely. `oError` is driven only by protocol errors.

## Test plan
- Single block "abc": words 0x61626380, 13×0, then 0x00000000, 0x00000018 with last on word 15 → one `oCoreStart`, `oCoreLastBlock`=1, `oDigest`=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", padded, with last on word 31 → two starts; the first has `oCoreLastBlock`=0. `oDigest`=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- `iWordLast` on word 5 → `oError` pulse of 1 cycle, no `oCoreStart`. A following valid "abc" stream still yields the correct digest.
- `iDigestReady` held low for 50 cycles → `oDigestValid` and `oDigest` stay stable and `oWordReady`=0 throughout. Raising `iDigestReady` makes `oWordReady`=1 in the next cycle.
- `iReset_n` asserted in WAIT → all outputs 0 immediately. After release, `oWordReady`=1 after one edge and a new "abc" hash is correct.
- With `SHA256_CTRL_WDT_EN`, `TIMEOUT_CYCLES`=16 and a core stub that never asserts done → `oError` pulses 16 cycles after WAIT entry, then `oWordReady`=1.
